regfile_write_scheduler: RTL and testbench
==========================================

// Module: regfile_write_scheduler
// PURPOSE
//   Shares the register file's single write port among P_NUM_REQ writeback sources (ALU, load unit, I/O).
//   Round-robin arbitration; drives the one-hot I_ENABLE and shared I_DATA of the P_NUM_REGS register instances.
//   Exposes the in-flight write so decode/read logic can forward it.
// PARAMETERS
//   P_WIDTH         16  data width of each register
//   P_NUM_REGS      16  number of registers; address width AW = $clog2(P_NUM_REGS)
//   P_NUM_REQ       3   number of write requesters (>= 2)
//   P_R0_HARDWIRED  0   1: writes to address 0 are accepted and discarded
// PORTS
//   I_CLK          in   1                  clock; all state updates on posedge
//   I_RESET        in   1                  synchronous, active-high reset
//   I_HOLD         in   1                  1: stall; no new grants this cycle
//   I_REQ_VALID    in   P_NUM_REQ          per-requester write request
//   I_REQ_ADDR     in   P_NUM_REQ*AW       packed target addresses; req i at [i*AW +: AW]
//   I_REQ_DATA     in   P_NUM_REQ*P_WIDTH  packed write data; req i at [i*P_WIDTH +: P_WIDTH]
//   O_REQ_READY    out  P_NUM_REQ          one-hot grant; a transfer occurs when VALID & READY
//   O_REG_ENABLE   out  P_NUM_REGS         one-hot write enable to the register instances
//   O_REG_DATA     out  P_WIDTH            write data to all register instances
//   O_GRANT_ID     out  $clog2(P_NUM_REQ)  ID of the requester whose write is in flight
//   O_PEND_VALID   out  1                  a write is in flight (O_REG_ENABLE cycle)
//   O_PEND_ADDR    out  AW                 address of the in-flight write, for forwarding
//   O_ADDR_ERR     out  1                  one-cycle pulse: accepted address was >= P_NUM_REGS
// BEHAVIOUR
//   Reset (I_RESET high at posedge):
//     - O_REG_ENABLE, O_REG_DATA, O_GRANT_ID, O_PEND_VALID, O_PEND_ADDR, O_ADDR_ERR go to 0.
//     - RR pointer goes to 0.
//     - Any in-flight write is dropped; no enable in the following cycle.
//   O_REQ_READY is combinational: 0 while I_RESET or I_HOLD is high.
//     - Otherwise it is the first VALID requester scanning ptr, ptr+1, ... mod P_NUM_REQ.
//     - At most one bit is set. READY never asserts for a requester whose VALID is low.
//   Handshake: a requester holds VALID/ADDR/DATA stable until it sees READY; then it may drop VALID.
//   Pipeline: one registered stage. Accept at edge k:
//     - O_REG_ENABLE, O_REG_DATA, O_PEND_*, O_GRANT_ID are valid throughout cycle k..k+1.
//     - The register captures the data at edge k+1.
//     - Stage is valid for exactly one cycle unless another accept follows (back-to-back: 1 write/cycle).
//   RR pointer: on accept from requester i, ptr <= (i+1) mod P_NUM_REQ. Unchanged when there is no accept.
//   Invalid address (>= P_NUM_REGS), or address 0 with P_R0_HARDWIRED=1:
//     - The request is still accepted (READY), and O_PEND_VALID=1.
//     - O_REG_ENABLE stays all-zero.
//     - O_ADDR_ERR pulses only for the out-of-range case.
//   O_REG_ENABLE has at most one bit set in every cycle.
//   Idle cycle (no accept): O_REG_ENABLE=0, O_PEND_VALID=0, O_REG_DATA holds its last value.
//   I_HOLD asserted mid-stream: the write accepted at the prior edge still completes; new grants stop.
//   Starvation bound: a continuously VALID requester is granted within P_NUM_REQ non-held cycles.
// STRUCTURE
//   Package regfile_sched_pkg holds:
//     - the AW / ID-width helper localparams;
//     - requester ID constants REQ_ALU=0, REQ_LOAD=1, REQ_IO=2;
//     - the write-stage struct {valid, addr, data, id}.
//   Sub-module rr_arbiter (P_N): req vector, advance strobe -> one-hot grant; owns the pointer register.
//   Top level contains the address decode to one-hot and the output stage register.
// TESTING
//   1. Reset, then req0 addr=5 data=16'hBEEF:
//      -> READY[0] in the same cycle; next cycle ENABLE=16'h0020, DATA=BEEF, PEND_ADDR=5.
//   2. All 3 VALID every cycle from ptr=0:
//      -> grants 0,1,2,0,1,2; one ENABLE pulse per cycle, no gaps.
//   3. req1 addr=0 with P_R0_HARDWIRED=1:
//      -> READY[1]=1, PEND_VALID=1, ENABLE=0, ADDR_ERR=0.
//   4. P_NUM_REGS=12, req2 addr=14:
//      -> accepted, ENABLE=0, ADDR_ERR high for exactly 1 cycle.
//   5. I_HOLD high for 3 cycles with req0 VALID:
//      -> READY=0 for those cycles; grant in the cycle HOLD falls.
//   6. I_RESET in the cycle after an accept:
//      -> ENABLE=0 next cycle, ptr=0, the register is not written.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
// The stage struct is sized for the default configuration.
package regfile_sched_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_NUM_REQ  = 3;

   // Width of an index into n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_AW  = clog2_min1(DEF_NUM_REGS);
   localparam int DEF_IDW = clog2_min1(DEF_NUM_REQ);

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_IO   = 2;

   typedef struct packed {
      logic                   valid;
      logic [DEF_AW-1:0]      addr;
      logic [DEF_WIDTH-1:0]   data;
      logic [DEF_IDW-1:0]     id;
   } wr_stage_t;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer; the pointer moves past the winner whenever the grant is taken.
module rr_arbiter
   import regfile_sched_pkg::*;
#(
   parameter  int P_N = 3,
   localparam int IDW = clog2_min1(P_N)
) (
   input  logic           I_CLK,
   input  logic           I_RESET,
   input  logic [P_N-1:0] I_REQ,
   input  logic           I_ADVANCE,
   output logic [P_N-1:0] O_GRANT,
   output logic [IDW-1:0] O_GRANT_ID
);

   logic [IDW-1:0]          ptr_reg;
   logic [IDW-1:0]          ptr_next;
   logic [P_N-1:0]          upper_mask;
   logic [P_N-1:0]          upper_req;
   logic [P_N-1:0]          pick_src;
   logic [P_N:0][IDW-1:0]   id_chain;

   genvar gi;
   generate
      for (gi = 0; gi < P_N; gi++) begin : g_mask
         assign upper_mask[gi] = (IDW'(gi) >= ptr_reg);
      end
   endgenerate

   // Requests at or above the pointer win; otherwise wrap to the lowest one.
   assign upper_req = I_REQ & upper_mask;
   assign pick_src  = (|upper_req) ? upper_req : I_REQ;
   assign O_GRANT   = pick_src & (~pick_src + P_N'(1));

   assign id_chain[0] = '0;
   generate
      for (gi = 0; gi < P_N; gi++) begin : g_enc
         assign id_chain[gi+1] = id_chain[gi] | (O_GRANT[gi] ? IDW'(gi) : '0);
      end
   endgenerate
   assign O_GRANT_ID = id_chain[P_N];

   assign ptr_next = (O_GRANT_ID == IDW'(P_N - 1)) ? '0 : O_GRANT_ID + IDW'(1);

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         ptr_reg <= '0;
      end else if (I_ADVANCE) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register file's single write port among several writeback
// sources: round-robin grant, address decode, one registered write stage.
module regfile_write_scheduler
   import regfile_sched_pkg::*;
#(
   parameter  int P_WIDTH        = DEF_WIDTH,
   parameter  int P_NUM_REGS     = DEF_NUM_REGS,
   parameter  int P_NUM_REQ      = DEF_NUM_REQ,
   parameter  int P_R0_HARDWIRED = 0,
   localparam int AW             = clog2_min1(P_NUM_REGS),
   localparam int IDW            = clog2_min1(P_NUM_REQ)
) (
   input  logic                         I_CLK,
   input  logic                         I_RESET,
   input  logic                         I_HOLD,
   input  logic [P_NUM_REQ-1:0]         I_REQ_VALID,
   input  logic [P_NUM_REQ*AW-1:0]      I_REQ_ADDR,
   input  logic [P_NUM_REQ*P_WIDTH-1:0] I_REQ_DATA,
   output logic [P_NUM_REQ-1:0]         O_REQ_READY,
   output logic [P_NUM_REGS-1:0]        O_REG_ENABLE,
   output logic [P_WIDTH-1:0]           O_REG_DATA,
   output logic [IDW-1:0]               O_GRANT_ID,
   output logic                         O_PEND_VALID,
   output logic [AW-1:0]                O_PEND_ADDR,
   output logic                         O_ADDR_ERR
);

   typedef struct packed {
      logic                valid;
      logic [AW-1:0]       addr;
      logic [P_WIDTH-1:0]  data;
      logic [IDW-1:0]      id;
   } stage_t;

   logic [P_NUM_REQ-1:0]              req_eligible;
   logic [P_NUM_REQ-1:0]              grant;
   logic [IDW-1:0]                    grant_id;
   logic                              accept;
   logic [P_NUM_REQ:0][AW-1:0]        addr_chain;
   logic [P_NUM_REQ:0][P_WIDTH-1:0]   data_chain;
   logic [AW-1:0]                     sel_addr;
   logic [P_WIDTH-1:0]                sel_data;
   logic                              in_range;
   logic                              r0_drop;
   logic                              write_ok;
   stage_t                            stage_reg;
   stage_t                            stage_next;
   logic [P_NUM_REGS-1:0]             enable_reg;
   logic [P_NUM_REGS-1:0]             enable_next;
   logic                              err_reg;
   logic                              err_next;

   assign req_eligible = (I_RESET || I_HOLD) ? '0 : I_REQ_VALID;

   rr_arbiter #(
      .P_N (P_NUM_REQ)
   ) u_arb (
      .I_CLK      (I_CLK),
      .I_RESET    (I_RESET),
      .I_REQ      (req_eligible),
      .I_ADVANCE  (accept),
      .O_GRANT    (grant),
      .O_GRANT_ID (grant_id)
   );

   assign accept      = |grant;
   assign O_REQ_READY = grant;

   // Grant is one-hot, so an AND-OR mux picks the winner's address and data.
   assign addr_chain[0] = '0;
   assign data_chain[0] = '0;
   genvar gi;
   generate
      for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_sel
         assign addr_chain[gi+1] = addr_chain[gi]
                                 | ({AW{grant[gi]}} & I_REQ_ADDR[gi*AW +: AW]);
         assign data_chain[gi+1] = data_chain[gi]
                                 | ({P_WIDTH{grant[gi]}} & I_REQ_DATA[gi*P_WIDTH +: P_WIDTH]);
      end
   endgenerate
   assign sel_addr = addr_chain[P_NUM_REQ];
   assign sel_data = data_chain[P_NUM_REQ];

   assign in_range = ({1'b0, sel_addr} < (AW+1)'(P_NUM_REGS));
   assign r0_drop  = (P_R0_HARDWIRED != 0) && (sel_addr == '0);
   assign write_ok = accept && in_range && !r0_drop;
   assign err_next = accept && !in_range;

   generate
      for (gi = 0; gi < P_NUM_REGS; gi++) begin : g_dec
         assign enable_next[gi] = write_ok && (sel_addr == AW'(gi));
      end
   endgenerate

   // Data, address and ID hold their last value through idle cycles.
   always_comb begin
      stage_next       = stage_reg;
      stage_next.valid = accept;
      if (accept) begin
         stage_next.addr = sel_addr;
         stage_next.data = sel_data;
         stage_next.id   = grant_id;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         stage_reg  <= '0;
         enable_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         stage_reg  <= stage_next;
         enable_reg <= enable_next;
         err_reg    <= err_next;
      end
   end

   // A write still in the stage when reset arrives must not land in the file.
   assign O_REG_ENABLE = I_RESET ? '0 : enable_reg;
   assign O_PEND_VALID = stage_reg.valid && !I_RESET;
   assign O_REG_DATA   = stage_reg.data;
   assign O_PEND_ADDR  = stage_reg.addr;
   assign O_GRANT_ID   = stage_reg.id;
   assign O_ADDR_ERR   = err_reg;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomised scoreboard bench: a driver predicts grants from a round-robin
// model and queues expected writes; a monitor checks the write stage.
module tb_regfile_write_scheduler;
   import regfile_sched_pkg::*;

   localparam int W     = 16;
   localparam int NREGS = 12;
   localparam int NREQ  = 3;
   localparam int AW    = 4;
   localparam int IDW   = 2;

   typedef struct {
      wr_stage_t          st;
      logic [NREGS-1:0]   en;
      logic               err;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 hold = 1'b0;
   logic [NREQ-1:0]      valid = '0;
   logic [NREQ*AW-1:0]   addr_bus = '0;
   logic [NREQ*W-1:0]    data_bus = '0;
   logic [NREQ-1:0]      ready;
   logic [NREGS-1:0]     reg_en;
   logic [W-1:0]         reg_data;
   logic [IDW-1:0]       grant_id;
   logic                 pend_valid;
   logic [AW-1:0]        pend_addr;
   logic                 addr_err;

   logic [NREQ-1:0]      pend_v;
   logic [AW-1:0]        pend_a [NREQ];
   logic [W-1:0]         pend_d [NREQ];
   int                   model_ptr;
   int                   checks = 0;
   int                   failures = 0;
   exp_t                 exp_q[$];

   always #5 clk = ~clk;

   regfile_write_scheduler #(
      .P_WIDTH        (W),
      .P_NUM_REGS     (NREGS),
      .P_NUM_REQ      (NREQ),
      .P_R0_HARDWIRED (1)
   ) dut (
      .I_CLK        (clk),
      .I_RESET      (rst),
      .I_HOLD       (hold),
      .I_REQ_VALID  (valid),
      .I_REQ_ADDR   (addr_bus),
      .I_REQ_DATA   (data_bus),
      .O_REQ_READY  (ready),
      .O_REG_ENABLE (reg_en),
      .O_REG_DATA   (reg_data),
      .O_GRANT_ID   (grant_id),
      .O_PEND_VALID (pend_valid),
      .O_PEND_ADDR  (pend_addr),
      .O_ADDR_ERR   (addr_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
      pend_v[i] = 1'b1;
      pend_a[i] = a;
      pend_d[i] = d;
   endtask

   task automatic refill(input int pct);
      for (int i = 0; i < NREQ; i++) begin
         if (!pend_v[i] && ($urandom_range(99) < pct))
            set_req(i, AW'($urandom_range(15)), W'($urandom));
      end
   endtask

   // One clock: drive inputs after the edge, predict and check READY mid-cycle.
   task automatic step(input logic r, input logic h);
      int g;
      logic [NREQ-1:0] exp_ready;
      exp_t e;
      @(posedge clk);
      #1;
      rst   = r;
      hold  = h;
      valid = pend_v;
      for (int i = 0; i < NREQ; i++) begin
         addr_bus[i*AW +: AW] = pend_a[i];
         data_bus[i*W +: W]   = pend_d[i];
      end
      @(negedge clk);
      g = -1;
      if (!r && !h) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (model_ptr + k) % NREQ;
            if (g < 0 && pend_v[i]) g = i;
         end
      end
      exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      check("ready", 32'(ready), 32'(exp_ready));
      if (g >= 0) begin
         e.st.valid = 1'b1;
         e.st.addr  = pend_a[g];
         e.st.data  = pend_d[g];
         e.st.id    = IDW'(g);
         e.err      = (int'(pend_a[g]) >= NREGS);
         e.en       = (!e.err && pend_a[g] != '0) ? (NREGS'(1) << pend_a[g]) : '0;
         exp_q.push_back(e);
         pend_v[g] = 1'b0;
         model_ptr = (g + 1) % NREQ;
      end
      if (r) model_ptr = 0;
   endtask

   // Monitor: compares the write stage against queued expectations.
   initial begin
      logic rst_edge;
      logic [W-1:0] last_data;
      exp_t e;
      last_data = '0;
      forever begin
         @(posedge clk);
         rst_edge = rst;
         @(negedge clk);
         if (rst) begin
            check("enable_during_reset", 32'(reg_en), 32'(0));
            exp_q.delete();
         end
         if (rst_edge) begin
            check("reset_enable", 32'(reg_en), 32'(0));
            check("reset_pend", 32'(pend_valid), 32'(0));
            check("reset_data", 32'(reg_data), 32'(0));
            check("reset_id", 32'(grant_id), 32'(0));
            check("reset_addr", 32'(pend_addr), 32'(0));
            check("reset_err", 32'(addr_err), 32'(0));
            last_data = '0;
         end else if (!rst) begin
            if (pend_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 32'(pend_valid), 32'(0));
               end else begin
                  e = exp_q.pop_front();
                  $display("write id=%0d addr=%0d data=0x%04h", e.st.id, e.st.addr, e.st.data);
                  check("enable", 32'(reg_en), 32'(e.en));
                  check("data", 32'(reg_data), 32'(e.st.data));
                  check("pend_addr", 32'(pend_addr), 32'(e.st.addr));
                  check("grant_id", 32'(grant_id), 32'(e.st.id));
                  check("addr_err", 32'(addr_err), 32'(e.err));
                  last_data = e.st.data;
               end
            end else begin
               check("idle_enable", 32'(reg_en), 32'(0));
               check("idle_err", 32'(addr_err), 32'(0));
               check("idle_data_hold", 32'(reg_data), 32'(last_data));
               check("missed_write", 32'(exp_q.size()), 32'(0));
               exp_q.delete();
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pend_v    = '0;
      model_ptr = 0;
      for (int i = 0; i < NREQ; i++) begin
         pend_a[i] = '0;
         pend_d[i] = '0;
      end
      repeat (3) step(1'b1, 1'b0);

      // Single write from the ALU port.
      set_req(REQ_ALU, 4'd5, 16'hBEEF);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // All sources busy from a fresh pointer: back-to-back 0,1,2,0,1,2.
      step(1'b1, 1'b0);
      for (int c = 0; c < 6; c++) begin
         refill(100);
         step(1'b0, 1'b0);
      end
      step(1'b0, 1'b0);

      // Hardwired r0 write and an out-of-range write.
      set_req(REQ_LOAD, 4'd0, 16'h1234);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      set_req(REQ_IO, 4'd14, 16'h5678);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Hold for three cycles, then release.
      set_req(REQ_ALU, 4'd3, 16'hA5A5);
      repeat (3) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Reset right after an accept: write dropped, pointer back to 0.
      set_req(REQ_ALU, 4'd7, 16'hC0DE);
      step(1'b0, 1'b0);
      set_req(REQ_LOAD, 4'd8, 16'h0101);
      set_req(REQ_IO, 4'd9, 16'h0202);
      step(1'b1, 1'b0);
      set_req(REQ_ALU, 4'd10, 16'h0303);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Random traffic with holds and occasional resets.
      for (int c = 0; c < 400; c++) begin
         refill(45);
         step(($urandom_range(99) < 2), ($urandom_range(99) < 15));
      end

      pend_v = '0;
      repeat (3) step(1'b0, 1'b0);
      check("queue_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
